// File: rtl/median_column_feeder.sv
// Line-buffered vertical 3-pixel column feeder for a 3x3 median filter front end.
// Optional macro MEDIAN_FEEDER_BORDER_REPLICATE_EN: emit columns from row 0 with top/bottom rows replicated.
module median_column_feeder #(
  parameter int IMG_WIDTH = 640,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        pix_in,
  input  logic              pix_valid,
  input  logic              frame_start,
  output logic [7:0]        top,
  output logic [7:0]        mid,
  output logic [7:0]        bot,
  output logic              col_valid,
  output logic [ADDR_W-1:0] col_x,
  output logic              line_last
);

  typedef enum logic [1:0] {FILL0, FILL1, STREAM} state_t;

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_WIDTH - 1);

  state_t            st, st_eff, st_nxt;
  logic [ADDR_W-1:0] x, x_eff, x_nxt;
  logic              eol, emit;
  logic [7:0]        lb0 [IMG_WIDTH];
  logic [7:0]        lb1 [IMG_WIDTH];
  logic [7:0]        lb0_rd, lb1_rd;
  logic [7:0]        c_top, c_mid, c_bot;

  // frame_start overrides position before the pixel in the same cycle is processed
  always_comb begin
    st_eff = frame_start ? FILL0 : st;
    x_eff  = frame_start ? '0 : x;
    eol    = (x_eff == X_LAST);
    st_nxt = st_eff;
    x_nxt  = x_eff;
    if (pix_valid) begin
      x_nxt = eol ? '0 : x_eff + 1'b1;
      if (eol) begin
        case (st_eff)
          FILL0:   st_nxt = FILL1;
          default: st_nxt = STREAM;
        endcase
      end
    end
  end

  assign lb0_rd = lb0[x_eff];
  assign lb1_rd = lb1[x_eff];

  always_comb begin
    c_top = lb1_rd;
    c_mid = lb0_rd;
    c_bot = pix_in;
`ifdef MEDIAN_FEEDER_BORDER_REPLICATE_EN
    emit = pix_valid;
    case (st_eff)
      FILL0: begin
        c_top = pix_in;
        c_mid = pix_in;
      end
      FILL1: c_top = lb0_rd;
      default: ;
    endcase
`else
    emit = pix_valid && (st_eff == STREAM);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= FILL0;
      x         <= '0;
      col_valid <= 1'b0;
      line_last <= 1'b0;
      top       <= '0;
      mid       <= '0;
      bot       <= '0;
      col_x     <= '0;
    end else begin
      st        <= st_nxt;
      x         <= x_nxt;
      col_valid <= emit;
      line_last <= emit && eol;
      // column registers hold while nothing is presented
      if (emit) begin
        top   <= c_top;
        mid   <= c_mid;
        bot   <= c_bot;
        col_x <= x_eff;
      end
    end
  end

  // storage is intentionally unreset; FILL states keep stale rows off the output
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1[x_eff] <= lb0_rd;
      lb0[x_eff] <= pix_in;
    end
  end

endmodule

// File: tb/tb_median_column_feeder.sv
// Scoreboard bench for median_column_feeder at IMG_WIDTH=4: directed rows, expected columns queued ahead.
module tb_median_column_feeder;
  localparam int W  = 4;
  localparam int AW = 2;

  typedef struct packed {
    logic [7:0]    t;
    logic [7:0]    m;
    logic [7:0]    b;
    logic [AW-1:0] x;
    logic          last;
  } col_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [7:0]    top, mid, bot;
  logic          col_valid, line_last;
  logic [AW-1:0] col_x;

  int   n_chk = 0;
  int   n_pass = 0;
  col_t exp_q[$];
  logic prev_pv = 1'b0;

  median_column_feeder #(.IMG_WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .frame_start(frame_start), .top(top), .mid(mid), .bot(bot),
    .col_valid(col_valid), .col_x(col_x), .line_last(line_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic push(input int t, input int m, input int b, input int x);
    col_t c;
    c.t = 8'(t); c.m = 8'(m); c.b = 8'(b); c.x = AW'(x); c.last = (x == W - 1);
    exp_q.push_back(c);
  endtask

  task automatic px(input int p, input bit fs = 1'b0);
    pix_in = 8'(p); pix_valid = 1'b1; frame_start = fs;
    @(posedge clk); #1;
    pix_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle();
    pix_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  always @(posedge clk) prev_pv <= pix_valid;

  // monitor: every presented column must match the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (!prev_pv) chk("col_valid_after_idle", col_valid, 0);
      if (col_valid) begin
        if (exp_q.size() == 0) chk("unexpected_col_valid", 1, 0);
        else begin
          col_t e;
          e = exp_q.pop_front();
          chk("top", top, e.t);
          chk("mid", mid, e.m);
          chk("bot", bot, e.b);
          chk("col_x", col_x, e.x);
          chk("line_last", line_last, e.last);
        end
      end else chk("line_last_idle", line_last, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_col_valid", col_valid, 0);
    chk("rst_line_last", line_last, 0);
    chk("rst_top", top, 0);
    chk("rst_mid", mid, 0);
    chk("rst_bot", bot, 0);
    chk("rst_col_x", col_x, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef MEDIAN_FEEDER_BORDER_REPLICATE_EN
    for (int c = 0; c < W; c++) begin push(10 + c, 10 + c, 10 + c, c); px(10 + c, c == 0); end
    for (int c = 0; c < W; c++) begin push(10 + c, 10 + c, 20 + c, c); px(20 + c); end
    for (int c = 0; c < W; c++) begin push(10 + c, 20 + c, 30 + c, c); px(30 + c); end
    idle();
`else
    // continuous frame; first column appears one cycle after pixel 30
    for (int c = 0; c < W; c++) px(10 + c, c == 0);
    for (int c = 0; c < W; c++) px(20 + c);
    for (int c = 0; c < W; c++) begin push(10 + c, 20 + c, 30 + c, c); px(30 + c); end
    // extremes across the line wrap
    push(20, 30, 0, 0);  px(0);
    push(21, 31, 41, 1); px(41);
    push(22, 32, 42, 2); px(42);
    push(23, 33, 255, 3); px(255);
    push(30, 0, 255, 0); px(255);
    push(31, 41, 51, 1); px(51);
    push(32, 42, 52, 2); px(52);
    push(33, 255, 0, 3); px(0);
    idle();

    // pix_valid alternating: same column sequence, never valid after an idle cycle
    for (int c = 0; c < W; c++) begin px(10 + c, c == 0); idle(); end
    for (int c = 0; c < W; c++) begin px(20 + c); idle(); end
    for (int c = 0; c < W; c++) begin push(10 + c, 20 + c, 30 + c, c); px(30 + c); idle(); end

    // frame restart at x=2: pixel 99 becomes (0,0)
    push(20, 30, 60, 0); px(60);
    push(21, 31, 61, 1); px(61);
    px(99, 1'b1);
    for (int c = 1; c < W; c++) px(c);
    for (int c = 0; c < W; c++) px(4 + c);
    push(99, 4, 8, 0); px(8);
    for (int c = 1; c < W; c++) begin push(c, 4 + c, 8 + c, c); px(8 + c); end
    push(4, 8, 20, 0); px(20);
    push(5, 9, 21, 1); px(21);
    idle();

    // short asynchronous reset between edges while streaming
    #1 rst_n = 1'b0;
    #1;
    chk("arst_col_valid", col_valid, 0);
    chk("arst_top", top, 0);
    chk("arst_mid", mid, 0);
    chk("arst_bot", bot, 0);
    chk("arst_col_x", col_x, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < W; c++) px(10 + c);
    for (int c = 0; c < W; c++) px(20 + c);
    for (int c = 0; c < W; c++) begin push(10 + c, 20 + c, 30 + c, c); px(30 + c); end
    idle();
`endif
    idle(); idle();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
